// File: rtl/prio_event_encoder.sv
// prio_event_encoder: synchronises an N-bit asynchronous request bus,
// detects rising edges, queues them in a pending register and reports them
// one at a time in priority order over a valid/ready handshake. A sticky
// overflow flag records an edge that arrived on a bit already pending.
module prio_event_encoder #(
    parameter int N          = 20,
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [N-1:0]         in,
    input  logic                 ready,
    input  logic                 clr_ovf,
    output logic [$clog2(N)-1:0] code,
    output logic                 valid,
    output logic                 overflow
);

    // Width of the encoded index; derived from N so that N-1 fits.
    localparam int W = $clog2(N);

    logic [N-1:0] sync1;
    logic [N-1:0] sync2;
    logic [N-1:0] prev;
    logic [N-1:0] pending;
    logic [N-1:0] edge_det;
    logic [N-1:0] clr_mask;
    logic [W-1:0] sel;
    logic         accept;
    logic         ovf_hit;

    // Two-flop synchroniser plus one history stage for edge detection.
    // Reset leaves prev at 0, so a line already high when nrst deasserts
    // is seen as a fresh edge and reported once.
    always_ff @(posedge clk or negedge nrst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // stage samples the value from before this clock edge.
        if (!nrst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign edge_det = sync2 & ~prev;

    // Priority selection: scan all bits, the last match in scan order wins.
    always_comb begin
        // NOTE: default first so no path leaves sel unassigned (no latch).
        sel = '0;
        if (HIGH_FIRST) begin
            for (int i = 0; i < N; i++) begin
                if (pending[i]) sel = W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (pending[i]) sel = W'(i);
            end
        end
    end

    assign valid  = |pending;
    assign code   = valid ? sel : '0;
    assign accept = valid & ready;

    // One-hot mask of the bit being consumed this cycle, and the overflow
    // condition: an edge landing on a bit that stays pending.
    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < N; i++) begin
            clr_mask[i] = accept && (sel == W'(i));
        end
        ovf_hit = |(edge_det & pending & ~clr_mask);
    end

    // Pending queue: consumed bit clears, new edges set (set wins, so an
    // edge on the bit being accepted re-queues it without overflow).
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | edge_det;
        end
    end

    // Sticky overflow; a new overflow takes precedence over clr_ovf.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            overflow <= 1'b0;
        end else if (ovf_hit) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: doc/prio_event_encoder.md
Name: prio_event_encoder

Overview:
- Parametrised, clocked successor to the 20-to-5 combinational encoder.
- Synchronises an N-bit asynchronous request bus (buttons, pads) and detects rising edges on each bit.
- Queues every new edge in a pending register, so simultaneous presses are not lost.
- Reports queued edges one at a time, in priority order, over a valid/ready handshake; a sticky flag records overflows.

Parameters:
- N, 20, number of request inputs; legal range 2..256.
- W, $clog2(N), width of the encoded index (5 for N=20); derived, not overridden.
- HIGH_FIRST, 1, 1 = highest index is served first; 0 = lowest index is served first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- nrst  input  1  reset, asynchronous, active-low.
- in  input  N  asynchronous request lines, active-high.
- ready  input  1  consumer accepts the current code this cycle.
- clr_ovf  input  1  synchronous clear of overflow.
- code  output  W  index of the highest-priority pending edge; 0 when valid=0.
- valid  output  1  at least one edge is pending.
- overflow  output  1  sticky: an edge arrived on a bit that was already pending.

Behaviour:
- Reset (nrst=0, asynchronous): sync1, sync2, prev, pending and overflow are cleared to 0 immediately, without waiting for a clock edge.
  - Outputs during and after reset: valid=0, code=0, overflow=0.
  - An input already high when nrst deasserts is treated as a new edge, reported once.
- Synchroniser: sync1<=in, sync2<=sync1, prev<=sync2.
  - edge[i] = sync2[i] & ~prev[i], combinational.
- Latency: an input rising before clock edge E0 sets pending at E2.
  - valid is high after E2, i.e. the 3rd rising edge counted from E0.
  - Pulses shorter than one clock period may be missed; a pulse held for 2 or more cycles is always captured.
- Selection, combinational from pending:
  - HIGH_FIRST=1 → sel = highest set index; HIGH_FIRST=0 → sel = lowest set index.
  - valid = |pending; code = sel when valid, else 0.
- Accept: an accept occurs when valid & ready are both high at a clock edge.
  - pending[sel] clears at that edge.
  - The next pending bit, if any, is presented in the following cycle; one event per cycle maximum, no bubbles.
- Pending update per bit i: pending[i] <= (pending[i] & ~clr_i) | edge[i], where clr_i = accept & (sel==i).
- Overflow:
  - Sets when edge[i] & pending[i] & ~clr_i, for any i.
  - Only one event is retained per bit; the duplicate is dropped.
  - Edge on a bit in the same cycle it is accepted: the bit re-sets with no overflow, and it is reported again later.
- clr_ovf:
  - clr_ovf=1 clears overflow at the next edge.
  - Same cycle as a new overflow condition: set wins, overflow stays 1.
- Held inputs: a level held high produces exactly one event. A falling edge produces no event.
- ready with valid=0: no effect.
- code is stable while valid=1 and ready=0, unless a higher-priority edge arrives. In that case code switches to the new index; the previous index stays pending.
- Arithmetic: selection is done by a loop over N; W is sized so that N-1 fits. No other arithmetic.

Test Plan:
- N=20, HIGH_FIRST=1, ready=1; pulse in[7] for 4 cycles → valid rises 3 edges after the first sample, code=7 for exactly one cycle, then valid=0, overflow=0.
- in[3] and in[12] rise in the same cycle, ready=1 → code=12 on cycle k, code=3 on cycle k+1, valid=0 on k+2.
- ready=0; pulse in[5] for 3 cycles, low 3 cycles, high 3 cycles → overflow=1. Raising ready gives a single code=5, then valid=0. Pulsing clr_ovf for one cycle gives overflow=0.
- Hold in[19] high for 100 cycles with ready=1 → exactly one accepted event, code=19. Releasing the input generates no event.
- HIGH_FIRST=0 instance; in[0] and in[19] rise together → code=0, then code=19. Separately, with ready=0 and pending={4}, raising in[2] → code changes from 4 to 2.
- Pending={2,9}, then drop nrst mid-cycle → valid, code and overflow are 0 before the next clock edge. Release nrst with in=0 → no events for 20 cycles.
